// File: rtl/dbnc_pkg.sv
// Shared types and limits for the push-button debounce sequencer.
package dbnc_pkg;

  typedef enum logic [2:0] {
    S_LO     = 3'd0,
    S_CHK_HI = 3'd1,
    S_DRN_HI = 3'd2,
    S_HI     = 3'd3,
    S_CHK_LO = 3'd4,
    S_DRN_LO = 3'd5
  } dbnc_state_e;

  localparam int unsigned DBNC_SYNC_MAX = 4;

  function automatic logic dbnc_is_busy(input dbnc_state_e s);
    return (s == S_CHK_HI) || (s == S_DRN_HI) || (s == S_CHK_LO) || (s == S_DRN_LO);
  endfunction

endpackage

// File: rtl/dbnc_sync.sv
// Input synchroniser for the raw button pin: SYNC_STAGES flops, synchronous reset.
module dbnc_sync
  import dbnc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  // Out-of-range depths are clamped into the supported 2..DBNC_SYNC_MAX window.
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 :
                                   (SYNC_STAGES > DBNC_SYNC_MAX) ? DBNC_SYNC_MAX : SYNC_STAGES;

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/dbnc_fsm.sv
// Debounce sequencer: synchronises the button, drives the timer start pulse, emits level/strobes.
// Release strobe on btn_rel only when DBNC_RELEASE_PULSE_EN is defined; otherwise btn_rel stays 0.
module dbnc_fsm
  import dbnc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic times_up,
  output logic strt,
  output logic btn_lvl,
  output logic btn_press,
  output logic btn_rel,
  output logic busy
);

  dbnc_state_e state_q, state_d;
  logic sync_in;
  logic strt_q, strt_d;
  logic lvl_q, lvl_d;
  logic press_q, press_d;
  logic rel_q, rel_d;
  logic busy_q, busy_d;

  dbnc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_in),
    .q_o (sync_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LO;
      strt_q  <= 1'b0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      strt_q  <= strt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
    end
  end

  // Idle states never start the timer while times_up is still high (drain rule).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LO:     if (sync_in && !times_up)  state_d = S_CHK_HI;
      S_CHK_HI: if (times_up)              state_d = sync_in ? S_DRN_HI : S_DRN_LO;
      S_DRN_HI: if (!times_up)             state_d = S_HI;
      S_HI:     if (!sync_in && !times_up) state_d = S_CHK_LO;
      S_CHK_LO: if (times_up)              state_d = sync_in ? S_DRN_HI : S_DRN_LO;
      S_DRN_LO: if (!times_up)             state_d = S_LO;
      default:                             state_d = S_LO;
    endcase
  end

  always_comb begin
    strt_d  = 1'b0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      S_LO: strt_d = sync_in && !times_up;
      S_HI: strt_d = !sync_in && !times_up;
      S_CHK_HI: begin
        if (times_up && sync_in) begin
          lvl_d   = 1'b1;
          press_d = 1'b1;
        end
      end
      S_CHK_LO: begin
        if (times_up && !sync_in) begin
          lvl_d = 1'b0;
`ifdef DBNC_RELEASE_PULSE_EN
          rel_d = 1'b1;
`endif
        end
      end
      default: ;
    endcase
    busy_d = dbnc_is_busy(state_d);
  end

  assign strt      = strt_q;
  assign btn_lvl   = lvl_q;
  assign btn_press = press_q;
  assign btn_rel   = rel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dbnc_fsm.sv
// Self-checking bench for dbnc_fsm: directed scenarios plus random button/timer activity.
module tb_dbnc_fsm;

  localparam int unsigned SYNC = 3;
`ifdef DBNC_RELEASE_PULSE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, btn_in, times_up;
  logic strt, btn_lvl, btn_press, btn_rel, busy;

  always #5 clk = ~clk;

  dbnc_fsm #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .times_up  (times_up),
    .strt      (strt),
    .btn_lvl   (btn_lvl),
    .btn_press (btn_press),
    .btn_rel   (btn_rel),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Timer model (stimulus side): reacts to the DUT's start pulse.
  int period = 20;
  int hold_len = 2;
  int cnt = 0;
  int hold = 0;

  // Reference model: accepted level, whether a check or a drain is in progress,
  // and the input delayed by the synchroniser depth.
  bit m_lvl, m_chk, m_drn;
  bit [SYNC-1:0] m_sq;
  bit e_strt, e_press, e_rel;

  int n_strt = 0, n_press = 0, n_rel = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_chk = 0; m_drn = 0; m_sq = '0;
    e_strt = 0; e_press = 0; e_rel = 0;
  endtask

  task automatic model_step(input bit r, input bit b, input bit tu);
    bit s;
    if (r) begin
      model_reset();
    end else begin
      s = m_sq[SYNC-1];
      e_strt = 0; e_press = 0; e_rel = 0;
      if (!m_chk && !m_drn) begin
        if (!tu && s != m_lvl) begin
          m_chk  = 1;
          e_strt = 1;
        end
      end else if (m_chk) begin
        if (tu) begin
          m_chk = 0;
          m_drn = 1;
          if (s != m_lvl) begin
            m_lvl = s;
            if (s) e_press = 1;
            else   e_rel   = REL_EN;
          end
        end
      end else if (!tu) begin
        m_drn = 0;
      end
      m_sq = {m_sq[SYNC-2:0], b};
    end
  endtask

  // f < 0: times_up from the timer model; otherwise f[0] forces times_up.
  task automatic cyc(input bit r, input bit b, input int f);
    bit tu;
    @(negedge clk);
    chk("strt",  32'(strt),      32'(e_strt));
    chk("lvl",   32'(btn_lvl),   32'(m_lvl));
    chk("press", 32'(btn_press), 32'(e_press));
    chk("rel",   32'(btn_rel),   32'(e_rel));
    chk("busy",  32'(busy),      32'(m_chk | m_drn));
    chk("excl",  32'(btn_press & btn_rel), 32'd0);
    n_strt  += int'(strt);
    n_press += int'(btn_press);
    n_rel   += int'(btn_rel);
    if (r) begin
      cnt = 0; hold = 0;
    end else if (strt) begin
      cnt = period; hold = 0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) hold = hold_len;
    end else if (hold > 0) begin
      hold--;
    end
    tu = (f < 0) ? (hold > 0) : f[0];
    rst = r; btn_in = b; times_up = tu;
    @(posedge clk);
    model_step(r, b, tu);
    cyc_n++;
  endtask

  initial begin
    int s0, p0, r0, len, noisy;
    bit b;
    rst = 1'b1; btn_in = 1'b0; times_up = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    repeat (3) cyc(1, 0, -1);

    // Clean press
    s0 = n_strt; p0 = n_press;
    repeat (40) cyc(0, 1, -1);
    chk("press_strt_once", 32'(n_strt - s0), 32'd1);
    chk("press_once",      32'(n_press - p0), 32'd1);

    // Stale expiry while releasing, then the release debounce
    s0 = n_strt; r0 = n_rel;
    repeat (5) cyc(0, 0, 1);
    chk("stale_no_strt", 32'(n_strt - s0), 32'd0);
    repeat (40) cyc(0, 0, -1);
    chk("rel_strt_once", 32'(n_strt - s0), 32'd1);
    chk("rel_count",     32'(n_rel - r0), 32'(REL_EN));

    // Bounce rejection
    s0 = n_strt; p0 = n_press;
    for (int k = 0; k < 4; k++) repeat (3) cyc(0, (k % 2 == 0), -1);
    repeat (40) cyc(0, 0, -1);
    chk("bounce_strt_once", 32'(n_strt - s0), 32'd1);
    chk("bounce_no_press",  32'(n_press - p0), 32'd0);

    // Reset in the middle of a press check
    repeat (SYNC + 3) cyc(0, 1, -1);
    cyc(1, 1, -1);
    repeat (40) cyc(0, 1, -1);
    repeat (40) cyc(0, 0, -1);

    // Random activity with varying timer period/hold and occasional times_up noise
    for (int seg = 0; seg < 60; seg++) begin
      period   = $urandom_range(2, 25);
      hold_len = $urandom_range(1, 6);
      noisy    = ($urandom_range(0, 9) == 0);
      b        = 1'($urandom_range(0, 1));
      len      = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) b = ~b;
        cyc(($urandom_range(0, 149) == 0), b,
            noisy ? int'($urandom_range(0, 1)) : -1);
      end
    end
    repeat (50) cyc(0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
